// File: rtl/dir_input_unit.sv
// dir_input_unit: synchronise, debounce and queue push-button presses as one-hot direction events.
// Optional auto-repeat of a single held key is enabled by defining DIR_AUTOREPEAT_EN.
`default_nettype none
`timescale 1ns/1ps

module dir_input_unit #(
  parameter int NUM_KEYS             = 4,
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int DEBOUNCE_CYCLES      = 250000,
  parameter int FIFO_DEPTH           = 4,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 12500000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_KEYS-1:0]           key_in,
  input  logic                          clear,
  input  logic                          dir_ready,
  output logic                          dir_valid,
  output logic [NUM_KEYS-1:0]           dir_onehot,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] pressed_raw;
  logic [NUM_KEYS-1:0] sync1, sync2;
  logic [NUM_KEYS-1:0] stable, stable_nxt, rise;
  logic [CNT_W-1:0]    db_cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    db_cnt_nxt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_vec;
  logic [NUM_KEYS-1:0] ev_a, sel;
  logic                multi;
  logic [NUM_KEYS-1:0] ev_b;
  logic                ev_b_valid, ev_b_multi;

  assign pressed_raw = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nxt[i] = sync2[i];
          rise[i]       = sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= pressed_raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

`ifdef DIR_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_D_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] REP_P_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, one_held, rep_hit;

  // Counter restarts from zero the edge a lone key's press is registered.
  assign one_held = (stable != '0) && ((stable & (stable - NUM_KEYS'(1))) == '0);
  assign rep_hit  = one_held && (rep_first ? (rep_cnt == REP_D_LAST) : (rep_cnt == REP_P_LAST));
  assign rep_vec  = rep_hit ? stable : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!one_held) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
  assign rep_vec = '0;
`endif

  // Lowest index wins; any other simultaneous event is reported as a drop.
  assign sel   = ev_a & (~ev_a + NUM_KEYS'(1));
  assign multi = |(ev_a & ~sel);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ev_a       <= '0;
      ev_b       <= '0;
      ev_b_valid <= 1'b0;
      ev_b_multi <= 1'b0;
    end else begin
      ev_a       <= rise | rep_vec;
      ev_b       <= sel;
      ev_b_valid <= |ev_a;
      ev_b_multi <= multi;
    end
  end

  logic [NUM_KEYS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wptr, rptr;
  logic                full, pop, push, drop;

  assign level      = wptr - rptr;
  assign full       = (level == LVL_FULL);
  assign dir_valid  = (wptr != rptr);
  assign pop        = dir_valid && dir_ready;
  assign push       = ev_b_valid && (!full || pop);
  assign drop       = ev_b_valid && ((full && !pop) || ev_b_multi);
  assign dir_onehot = dir_valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW + 1)'(1);
      if (pop)  rptr <= rptr + (AW + 1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wptr[AW-1:0]] <= ev_b;
  end

endmodule

`default_nettype wire
